// File: rtl/mem_arbiter_if.sv
// Bundles the per-core mem_* request buses and the shared RAM port.
// 'slave' is the arbiter's view; 'master' is the cores-plus-RAM view.
interface mem_arbiter_if #(
    parameter int N_CORES = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32
);
    logic [N_CORES-1:0]        core_mem_read;
    logic [N_CORES-1:0]        core_mem_write;
    logic [N_CORES-1:0]        core_mem_atomic;
    logic [N_CORES*ADDR_W-1:0] core_mem_addr;
    logic [N_CORES*DATA_W-1:0] core_mem_data_w;
    logic [DATA_W-1:0]         core_mem_data_r;
    logic [N_CORES-1:0]        core_mem_wait;

    logic                      ram_mem_read;
    logic                      ram_mem_write;
    logic                      ram_mem_atomic;
    logic [ADDR_W-1:0]         ram_mem_addr;
    logic [DATA_W-1:0]         ram_mem_data_w;
    logic [DATA_W-1:0]         ram_mem_data_r;
    logic                      ram_mem_wait;

    modport slave (
        input  core_mem_read, core_mem_write, core_mem_atomic, core_mem_addr, core_mem_data_w,
        output core_mem_data_r, core_mem_wait,
        output ram_mem_read, ram_mem_write, ram_mem_atomic, ram_mem_addr, ram_mem_data_w,
        input  ram_mem_data_r, ram_mem_wait
    );

    modport master (
        output core_mem_read, core_mem_write, core_mem_atomic, core_mem_addr, core_mem_data_w,
        input  core_mem_data_r, core_mem_wait,
        input  ram_mem_read, ram_mem_write, ram_mem_atomic, ram_mem_addr, ram_mem_data_w,
        output ram_mem_data_r, ram_mem_wait
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between N_CORES cores, with
// a bus lock held from an atomic load until the owner's store or a timeout.
module mem_arbiter #(
    parameter int N_CORES      = 4,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(N_CORES);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_CORES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   gnt_q, gnt_d;
    logic [PTR_W-1:0]   lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0]   lock_cnt_inc;

    logic [N_CORES-1:0] req;
    logic [N_CORES-1:0] core_wait;
    logic               sel_valid;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   cand;
    logic               done;
    logic               sel_wr;
    logic               sel_atomic_rd;
    logic [ADDR_W-1:0]  core_addr  [N_CORES];
    logic [DATA_W-1:0]  core_wdata [N_CORES];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int unsigned k = 0; k < N_CORES; k++) begin
            core_addr[k]  = bus.core_mem_addr[k*ADDR_W +: ADDR_W];
            core_wdata[k] = bus.core_mem_data_w[k*DATA_W +: DATA_W];
        end
    end

    // Grant selection is combinational so a lone requester reaches RAM in the same cycle.
    always_comb begin
        req       = bus.core_mem_read | bus.core_mem_write;
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        case (state_q)
            IDLE: begin
                for (int unsigned k = 0; k < N_CORES; k++) begin
                    cand = PTR_W'((32'(rr_ptr_q) + k) % N_CORES);
                    if (!sel_valid && req[cand]) begin
                        sel_valid = 1'b1;
                        sel_idx   = cand;
                    end
                end
            end
            BUSY: begin
                sel_valid = 1'b1;
                sel_idx   = gnt_q;
            end
            LOCKED: begin
                sel_valid = req[lock_owner_q];
                sel_idx   = lock_owner_q;
            end
            default: ;
        endcase
        if (rst) begin
            sel_valid = 1'b0;
        end
    end

    assign done          = sel_valid & ~bus.ram_mem_wait;
    assign sel_wr        = bus.core_mem_write[sel_idx];
    assign sel_atomic_rd = bus.core_mem_read[sel_idx] & ~bus.core_mem_write[sel_idx]
                         & bus.core_mem_atomic[sel_idx];

    assign bus.ram_mem_read    = sel_valid & bus.core_mem_read[sel_idx];
    assign bus.ram_mem_write   = sel_valid & bus.core_mem_write[sel_idx];
    assign bus.ram_mem_atomic  = sel_valid & bus.core_mem_atomic[sel_idx];
    assign bus.ram_mem_addr    = sel_valid ? core_addr[sel_idx]  : '0;
    assign bus.ram_mem_data_w  = sel_valid ? core_wdata[sel_idx] : '0;
    assign bus.core_mem_data_r = bus.ram_mem_data_r;
    assign bus.core_mem_wait   = core_wait;

    always_comb begin
        core_wait = '0;
        for (int unsigned k = 0; k < N_CORES; k++) begin
            core_wait[k] = req[k] & ~(done && (sel_idx == PTR_W'(k)));
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_d        = gnt_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        lock_cnt_inc = lock_cnt_q + 1'b1;
        case (state_q)
            IDLE, BUSY: begin
                if (done) begin
                    rr_ptr_d = ptr_inc(sel_idx);
                    if (sel_atomic_rd) begin
                        state_d      = LOCKED;
                        lock_owner_d = sel_idx;
                        lock_cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (state_q == IDLE && sel_valid) begin
                    gnt_d   = sel_idx;
                    state_d = BUSY;
                end
            end
            LOCKED: begin
                if (done) begin
                    rr_ptr_d = ptr_inc(sel_idx);
                end
                // A repeated atomic load by the owner restarts the lock window.
                if (done && sel_atomic_rd) begin
                    lock_cnt_d = '0;
                end else if ((done && sel_wr) || lock_cnt_inc == CNT_LAST) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            lock_owner_q <= '0;
            lock_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small RAM model plus a completion scoreboard.
module tb_mem_arbiter;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_stall = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          core;
        logic [31:0] addr;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    bit [NC-1:0] completed;
    logic [31:0] mem [512];

    always #5 clk = ~clk;

    mem_arbiter_if #(.N_CORES(NC), .DATA_W(32), .ADDR_W(32)) bus ();

    mem_arbiter #(
        .N_CORES(NC), .DATA_W(32), .ADDR_W(32), .LOCK_TIMEOUT(64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: reset preloads mem[a] = a/50 (so mem[200] = 4).
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'(i / 50);
        end else if (bus.ram_mem_write && !ram_stall) begin
            mem[bus.ram_mem_addr[8:0]] <= bus.ram_mem_data_w;
        end
    end
    assign bus.ram_mem_data_r = mem[bus.ram_mem_addr[8:0]];
    assign bus.ram_mem_wait   = ram_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int c, input bit rd, input bit wr, input bit at,
                           input logic [31:0] a, input logic [31:0] d);
        bus.core_mem_read[c]          = rd;
        bus.core_mem_write[c]         = wr;
        bus.core_mem_atomic[c]        = at;
        bus.core_mem_addr[c*32 +: 32]   = a;
        bus.core_mem_data_w[c*32 +: 32] = d;
    endtask

    task automatic push(input int c, input logic [31:0] a, input bit rd, input logic [31:0] d);
        exp_t e;
        e.core = c; e.addr = a; e.rd = rd; e.data = d;
        sb.push_back(e);
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    // Compare each completing access against the scoreboard, then advance and retire it.
    task automatic fin();
        exp_t e;
        completed = '0;
        for (int c = 0; c < NC; c++) begin
            if ((bus.core_mem_read[c] || bus.core_mem_write[c]) && !bus.core_mem_wait[c]) begin
                completed[c] = 1'b1;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_core", 64'(c), 64'hFF);
                end else begin
                    e = sb.pop_front();
                    chk("sb_core", 64'(c), 64'(e.core));
                    chk("sb_addr", bus.ram_mem_addr, e.addr);
                    if (e.rd) chk("sb_rdata", bus.core_mem_data_r, e.data);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            if (completed[c]) set_req(c, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic cyc();
        half();
        fin();
    endtask

    initial begin
        int granted_at;
        bus.core_mem_read   = '0;
        bus.core_mem_write  = '0;
        bus.core_mem_atomic = '0;
        bus.core_mem_addr   = '0;
        bus.core_mem_data_w = '0;

        // Reset state
        @(posedge clk); #1;
        half();
        chk("rst_strobes", {bus.ram_mem_read, bus.ram_mem_write, bus.ram_mem_atomic}, 3'b000);
        chk("rst_wait_idle", bus.core_mem_wait, 4'b0000);
        fin();
        set_req(0, 1, 0, 0, 32'd100, 32'h0);
        half();
        chk("rst_wait_eq_req", bus.core_mem_wait, 4'b0001);
        chk("rst_no_read", bus.ram_mem_read, 1'b0);
        fin();
        set_req(0, 0, 0, 0, 32'h0, 32'h0);
        rst = 1'b0;
        half();
        chk("idle_addr_zero", bus.ram_mem_addr, 32'h0);
        fin();

        // 1: lone read, zero added latency
        set_req(0, 1, 0, 0, 32'd200, 32'h0);
        push(0, 32'd200, 1, 32'd4);
        half();
        chk("t1_read", bus.ram_mem_read, 1'b1);
        chk("t1_addr", bus.ram_mem_addr, 32'd200);
        chk("t1_wait", bus.core_mem_wait, 4'b0000);
        fin();

        // 2: four simultaneous readers served in round-robin order from rr_ptr=0
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int c = 0; c < NC; c++) begin
            set_req(c, 1, 0, 0, 32'(100 * (c + 1)), 32'h0);
            push(c, 32'(100 * (c + 1)), 1, 32'(2 * (c + 1)));
        end
        for (int k = 0; k < NC; k++) begin
            half();
            chk("t2_addr", bus.ram_mem_addr, 32'(100 * (k + 1)));
            chk("t2_wait", bus.core_mem_wait, 4'(4'b1110 << k));
            fin();
        end

        // 3: RAM stall holds core1's access for 4 cycles, core2 waits behind it
        set_req(1, 1, 0, 0, 32'd100, 32'h0);
        set_req(2, 1, 0, 0, 32'd200, 32'h0);
        push(1, 32'd100, 1, 32'd2);
        push(2, 32'd200, 1, 32'd4);
        for (int s = 0; s < 4; s++) begin
            ram_stall = (s < 3);
            half();
            chk("t3_addr_hold", bus.ram_mem_addr, 32'd100);
            chk("t3_wait", bus.core_mem_wait, (s < 3) ? 4'b0110 : 4'b0100);
            fin();
        end
        half();
        chk("t3_core2_addr", bus.ram_mem_addr, 32'd200);
        fin();

        // 4: core0 atomic pair locks out core1's write to the same address
        set_req(0, 1, 0, 1, 32'd300, 32'h0);
        push(0, 32'd300, 1, 32'd6);
        cyc();
        set_req(1, 0, 1, 0, 32'd300, 32'hAA);
        for (int k = 0; k < 2; k++) begin
            half();
            chk("t4_locked_wait", bus.core_mem_wait, 4'b0010);
            chk("t4_locked_nowrite", bus.ram_mem_write, 1'b0);
            fin();
        end
        set_req(0, 0, 1, 1, 32'd300, 32'h55);
        push(0, 32'd300, 0, 32'h0);
        push(1, 32'd300, 0, 32'h0);
        half();
        chk("t4_store_a_data", bus.ram_mem_data_w, 32'h55);
        chk("t4_store_a_atomic", bus.ram_mem_atomic, 1'b1);
        fin();
        half();
        chk("t4_core1_data", bus.ram_mem_data_w, 32'hAA);
        fin();
        set_req(2, 1, 0, 0, 32'd300, 32'h0);
        push(2, 32'd300, 1, 32'hAA);
        cyc();

        // 5: lock timeout; owner's plain read does not release it
        set_req(2, 1, 0, 1, 32'd400, 32'h0);
        push(2, 32'd400, 1, 32'd8);
        cyc();
        set_req(2, 1, 0, 0, 32'd100, 32'h0);
        set_req(3, 1, 0, 0, 32'd100, 32'h0);
        push(2, 32'd100, 1, 32'd2);
        push(3, 32'd100, 1, 32'd2);
        granted_at = -1;
        for (int k = 1; k <= 150 && granted_at < 0; k++) begin
            half();
            if (k == 1) chk("t5_owner_only", bus.core_mem_wait, 4'b1000);
            if (k == 30) chk("t5_still_locked", bus.ram_mem_read, 1'b0);
            if (!bus.core_mem_wait[3]) granted_at = k;
            fin();
        end
        chk("t5_timeout_cycle", 64'(granted_at), 64'd64);

        // 6: reset while locked with RAM stalled abandons everything
        set_req(2, 1, 0, 1, 32'd200, 32'h0);
        push(2, 32'd200, 1, 32'd4);
        cyc();
        ram_stall = 1'b1;
        set_req(2, 1, 0, 0, 32'd300, 32'h0);
        set_req(0, 1, 0, 0, 32'd100, 32'h0);
        set_req(3, 1, 0, 0, 32'd400, 32'h0);
        half();
        chk("t6_owner_stalled", bus.ram_mem_addr, 32'd300);
        chk("t6_wait_locked", bus.core_mem_wait, 4'b1101);
        fin();
        rst = 1'b1;
        half();
        chk("t6_rst_strobes", {bus.ram_mem_read, bus.ram_mem_write}, 2'b00);
        chk("t6_rst_wait", bus.core_mem_wait, 4'b1101);
        fin();
        rst = 1'b0;
        ram_stall = 1'b0;
        set_req(2, 0, 0, 0, 32'h0, 32'h0);
        push(0, 32'd100, 1, 32'd2);
        push(3, 32'd400, 1, 32'd8);
        half();
        chk("t6_lowest_first", bus.ram_mem_addr, 32'd100);
        fin();
        half();
        chk("t6_then_core3", bus.ram_mem_addr, 32'd400);
        fin();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
